// File: rtl/posterise_detect.sv
// Detects the upstream posterise level (off, lv1..lv5) by AND-accumulating every active colour byte per frame.
// Latency: status updates one clock after the registered vsync rising edge. No backpressure; the input stream is never stalled.
// Optional POSTERISE_DETECT_STATS_EN adds acc_mask/pix_count outputs latched at each frame end.
module posterise_detect #(
    parameter int MIN_PIXELS  = 1024,
    parameter int LOCK_FRAMES = 3,
    parameter int PIX_CNT_W   = 22
) (
    input  logic                 PixelClk,
    input  logic                 aRst,
    input  logic [23:0]          vid_pData,
    input  logic                 vid_pVDE,
    input  logic                 vid_pVSync,
    output logic [2:0]           mode_out,
    output logic                 mode_locked,
    output logic                 frame_done
`ifdef POSTERISE_DETECT_STATS_EN
    ,
    output logic [7:0]           acc_mask,
    output logic [PIX_CNT_W-1:0] pix_count
`endif
);

    localparam logic [PIX_CNT_W-1:0] MIN_PIX_C = PIX_CNT_W'(MIN_PIXELS);
    localparam logic [PIX_CNT_W-1:0] PIX_MAX_C = '1;
    localparam logic [PIX_CNT_W-1:0] PIX_ONE_C = PIX_CNT_W'(1);
    localparam logic [3:0]           LOCK_C    = 4'(LOCK_FRAMES);
    localparam logic [3:0]           MATCH_MAX = 4'd15;

    // Priority matters: a byte that passes 0x7F also passes every looser mask.
    function automatic logic [2:0] classify(input logic [7:0] a);
        if      ((a & 8'h7F) == 8'h7F) return 3'd1;
        else if ((a & 8'h3D) == 8'h3D) return 3'd2;
        else if ((a & 8'h1F) == 8'h1F) return 3'd3;
        else if ((a & 8'h0F) == 8'h0F) return 3'd4;
        else if ((a & 8'h07) == 8'h07) return 3'd5;
        else                           return 3'd0;
    endfunction

    logic [23:0]          data_q;
    logic                 vde_q;
    logic                 vs_q;
    logic                 vs_prev_q;

    logic [7:0]           acc_q,       acc_d;
    logic [PIX_CNT_W-1:0] pix_cnt_q,   pix_cnt_d;
    logic [2:0]           last_cand_q, last_cand_d;
    logic [3:0]           match_q,     match_d;
    logic [2:0]           mode_q,      mode_d;
    logic                 locked_q,    locked_d;
    logic                 done_q,      done_d;

    logic                 frame_end;
    logic [7:0]           pix_and;
    logic [2:0]           cand;
    logic [3:0]           match_new;
    logic [PIX_CNT_W-1:0] pix_cnt_inc;

    always_ff @(posedge PixelClk or posedge aRst) begin
        if (aRst) begin
            data_q    <= '0;
            vde_q     <= 1'b0;
            vs_q      <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            data_q    <= vid_pData;
            vde_q     <= vid_pVDE;
            vs_q      <= vid_pVSync;
            vs_prev_q <= vs_q;
        end
    end

    assign frame_end   = vs_q & ~vs_prev_q;
    assign pix_and     = data_q[23:16] & data_q[15:8] & data_q[7:0];
    assign cand        = classify(acc_q);
    assign pix_cnt_inc = (pix_cnt_q == PIX_MAX_C) ? pix_cnt_q : pix_cnt_q + PIX_ONE_C;

    always_comb begin
        acc_d       = acc_q;
        pix_cnt_d   = pix_cnt_q;
        last_cand_d = last_cand_q;
        match_d     = match_q;
        mode_d      = mode_q;
        locked_d    = locked_q;
        done_d      = 1'b0;
        match_new   = 4'd1;

        if (cand == last_cand_q)
            match_new = (match_q == MATCH_MAX) ? match_q : match_q + 4'd1;

        if (frame_end) begin
            done_d    = 1'b1;
            // An active pixel coinciding with the sync edge belongs to the next frame.
            acc_d     = vde_q ? pix_and   : 8'hFF;
            pix_cnt_d = vde_q ? PIX_ONE_C : '0;
            if (pix_cnt_q >= MIN_PIX_C) begin
                last_cand_d = cand;
                match_d     = match_new;
                if (cand != last_cand_q)
                    locked_d = 1'b0;
                if (match_new >= LOCK_C) begin
                    mode_d   = cand;
                    locked_d = 1'b1;
                end
            end
        end else if (vde_q) begin
            acc_d     = acc_q & pix_and;
            pix_cnt_d = pix_cnt_inc;
        end
    end

    always_ff @(posedge PixelClk or posedge aRst) begin
        if (aRst) begin
            acc_q       <= 8'hFF;
            pix_cnt_q   <= '0;
            last_cand_q <= 3'd0;
            match_q     <= 4'd0;
            mode_q      <= 3'd0;
            locked_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            pix_cnt_q   <= pix_cnt_d;
            last_cand_q <= last_cand_d;
            match_q     <= match_d;
            mode_q      <= mode_d;
            locked_q    <= locked_d;
            done_q      <= done_d;
        end
    end

    assign mode_out    = mode_q;
    assign mode_locked = locked_q;
    assign frame_done  = done_q;

`ifdef POSTERISE_DETECT_STATS_EN
    logic [7:0]           acc_mask_q;
    logic [PIX_CNT_W-1:0] pix_count_q;

    // Latched for ignored frames too, so short frames remain observable.
    always_ff @(posedge PixelClk or posedge aRst) begin
        if (aRst) begin
            acc_mask_q  <= '0;
            pix_count_q <= '0;
        end else if (frame_end) begin
            acc_mask_q  <= acc_q;
            pix_count_q <= pix_cnt_q;
        end
    end

    assign acc_mask  = acc_mask_q;
    assign pix_count = pix_count_q;
`endif

endmodule

// File: tb/tb_posterise_detect.sv
// Scoreboard bench for posterise_detect: frames push expected status, a monitor checks each frame_done pulse.
module tb_posterise_detect;

    localparam int PIX_CNT_W = 22;

    logic                 PixelClk;
    logic                 aRst;
    logic [23:0]          vid_pData;
    logic                 vid_pVDE;
    logic                 vid_pVSync;
    logic [2:0]           mode_out;
    logic                 mode_locked;
    logic                 frame_done;
`ifdef POSTERISE_DETECT_STATS_EN
    logic [7:0]           acc_mask;
    logic [PIX_CNT_W-1:0] pix_count;
`endif

    posterise_detect #(
        .MIN_PIXELS (1024),
        .LOCK_FRAMES(3),
        .PIX_CNT_W  (PIX_CNT_W)
    ) dut (
        .PixelClk   (PixelClk),
        .aRst       (aRst),
        .vid_pData  (vid_pData),
        .vid_pVDE   (vid_pVDE),
        .vid_pVSync (vid_pVSync),
        .mode_out   (mode_out),
        .mode_locked(mode_locked),
        .frame_done (frame_done)
`ifdef POSTERISE_DETECT_STATS_EN
        ,
        .acc_mask   (acc_mask),
        .pix_count  (pix_count)
`endif
    );

    initial PixelClk = 1'b0;
    always #5 PixelClk = ~PixelClk;

    typedef struct {
        logic [2:0] mode;
        logic       locked;
        logic [7:0] acc;
        int         cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    logic [7:0] seed_acc = 8'hFF;
    int         seed_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge PixelClk) begin
        if (!aRst && frame_done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame_done: got pulse at %0t, expected none", $time);
            end else begin
                mon_e = sb.pop_front();
                check("mode_out",    32'(mode_out),    32'(mon_e.mode));
                check("mode_locked", 32'(mode_locked), 32'(mon_e.locked));
`ifdef POSTERISE_DETECT_STATS_EN
                check("acc_mask",    32'(acc_mask),    32'(mon_e.acc));
                check("pix_count",   32'(pix_count),   32'(mon_e.cnt));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge PixelClk);
        #1;
    endtask

    // First pixel is exactly 'base' on every channel so the frame AND equals base
    // whenever the random bytes cannot add bits beyond it.
    task automatic send_frame(input int n_pix, input logic [7:0] base, input logic edge_px,
                              input logic [2:0] emode, input logic elock);
        exp_t       e;
        logic [7:0] acc;
        logic [7:0] r, g, b;
        int         cnt;
        acc = seed_acc;
        cnt = seed_cnt;
        for (int i = 0; i < n_pix; i++) begin
            if (i == 0) begin
                r = base; g = base; b = base;
            end else begin
                r = 8'($urandom_range(0, 255)) | base;
                g = 8'($urandom_range(0, 255)) | base;
                b = 8'($urandom_range(0, 255)) | base;
            end
            vid_pData = {r, g, b};
            vid_pVDE  = 1'b1;
            acc       = acc & r & g & b;
            cnt++;
            tick();
        end
        vid_pVDE  = 1'b0;
        vid_pData = 24'h0;
        repeat (4) tick();
        e.mode = emode; e.locked = elock; e.acc = acc; e.cnt = cnt;
        sb.push_back(e);
        vid_pVSync = 1'b1;
        if (edge_px) begin
            vid_pVDE  = 1'b1;
            vid_pData = 24'h000000;
        end
        tick();
        vid_pVDE = 1'b0;
        repeat (7) tick();
        vid_pVSync = 1'b0;
        repeat (4) tick();
        seed_acc = edge_px ? 8'h00 : 8'hFF;
        seed_cnt = edge_px ? 1 : 0;
    endtask

    initial begin
        aRst       = 1'b1;
        vid_pData  = 24'h0;
        vid_pVDE   = 1'b0;
        vid_pVSync = 1'b0;
        #1;
        check("reset_mode_out",    32'(mode_out),    32'd0);
        check("reset_mode_locked", 32'(mode_locked), 32'd0);
        check("reset_frame_done",  32'(frame_done),  32'd0);
        repeat (3) tick();
        aRst = 1'b0;
        repeat (4) tick();

        // lv3 lock-in
        send_frame(2048, 8'h1F, 1'b0, 3'd0, 1'b0);
        send_frame(2048, 8'h1F, 1'b0, 3'd0, 1'b0);
        send_frame(2048, 8'h1F, 1'b0, 3'd3, 1'b1);
        // plain random: unlock, hold 3, then lock at 0
        send_frame(2048, 8'h00, 1'b0, 3'd3, 1'b0);
        send_frame(2048, 8'h00, 1'b0, 3'd3, 1'b0);
        send_frame(2048, 8'h00, 1'b0, 3'd0, 1'b1);
        // lv2 (first pixel clears bits 6 and 1)
        send_frame(2048, 8'h3D, 1'b0, 3'd0, 1'b0);
        send_frame(2048, 8'h3D, 1'b0, 3'd0, 1'b0);
        send_frame(2048, 8'h3D, 1'b0, 3'd2, 1'b1);
        // short lv5 frame is ignored
        send_frame(500, 8'h07, 1'b0, 3'd2, 1'b1);
        // lv4, last frame carries an active pixel of 0x00 in the edge cycle
        send_frame(2048, 8'h0F, 1'b0, 3'd2, 1'b0);
        send_frame(2048, 8'h0F, 1'b0, 3'd2, 1'b0);
        send_frame(2048, 8'h0F, 1'b1, 3'd4, 1'b1);
        // seeded with 0x00 -> classifies 0
        send_frame(2048, 8'h0F, 1'b0, 3'd4, 1'b0);
        send_frame(1100, 8'h0F, 1'b0, 3'd4, 1'b0);
        send_frame(1100, 8'h0F, 1'b0, 3'd4, 1'b0);
        send_frame(1100, 8'h0F, 1'b0, 3'd4, 1'b1);

        // Mid-frame asynchronous reset with zero pixels that must be discarded
        for (int i = 0; i < 300; i++) begin
            vid_pData = 24'h000000;
            vid_pVDE  = 1'b1;
            tick();
        end
        #2;
        aRst = 1'b1;
        #1;
        check("midrst_mode_out",    32'(mode_out),    32'd0);
        check("midrst_mode_locked", 32'(mode_locked), 32'd0);
        check("midrst_frame_done",  32'(frame_done),  32'd0);
`ifdef POSTERISE_DETECT_STATS_EN
        check("midrst_acc_mask",    32'(acc_mask),    32'd0);
        check("midrst_pix_count",   32'(pix_count),   32'd0);
`endif
        repeat (3) tick();
        vid_pVDE = 1'b0;
        aRst     = 1'b0;
        seed_acc = 8'hFF;
        seed_cnt = 0;
        repeat (20) tick();

        // all-white frames classify as lv1 and start from fresh hysteresis
        send_frame(1500, 8'hFF, 1'b0, 3'd0, 1'b0);
        send_frame(1500, 8'hFF, 1'b0, 3'd0, 1'b0);
        send_frame(1500, 8'hFF, 1'b0, 3'd1, 1'b1);

        repeat (20) tick();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/posterise_detect.md
Name: posterise_detect

Overview:
- Analyses a video stream and reports which posterise level was applied upstream: off, or lv1..lv5.
- Lv1..lv5 force the low bits of every colour byte to 1 using masks 0x7F, 0x3D, 0x1F, 0x0F, 0x07.
- Sits on the vid_pData bus downstream of the effects chain and feeds status and auto-config logic.
- Works per frame: AND-accumulates every active byte, classifies at frame end, and only reports a level after it is stable for several frames.

Parameters:
- MIN_PIXELS, 1024, minimum active pixels for a frame to be classified; frames with fewer are ignored.
- LOCK_FRAMES, 3, consecutive identical classifications required before mode_out updates (range 1..15).
- PIX_CNT_W, 22, width of the saturating active-pixel counter.

Ports:
- PixelClk  in  1  pixel clock; all logic on rising edge.
- aRst  in  1  asynchronous reset, active-high.
- vid_pData  in  24  pixel, three 8-bit colour bytes; channel order irrelevant.
- vid_pVDE  in  1  active-video qualifier.
- vid_pVSync  in  1  vertical sync, active-high; rising edge marks frame end.
- mode_out  out  3  detected level, encoded the same as the posterise mode input (000 = none, 001..101 = lv1..lv5).
- mode_locked  out  1  1 while mode_out reflects LOCK_FRAMES matching frames.
- frame_done  out  1  one-cycle pulse per classified or ignored frame end.

Behaviour:
- Reset: asynchronous, active-high, one clock. Under aRst:
  - all outputs 0;
  - acc = 0xFF; pix_cnt = 0;
  - last_cand = 0; match_cnt = 0.
- Stage 1: register vid_pData, vid_pVDE and vid_pVSync. Keep vs_d, the previous registered vsync. edge = vs_r & ~vs_d.
- Accumulate, when vde_r=1 and edge=0:
  - acc <= acc & R & G & B;
  - pix_cnt <= pix_cnt + 1, saturating at 2^PIX_CNT_W - 1.
- Frame end, on the cycle where edge=1:
  - frame_done <= 1 for that one cycle.
  - If pix_cnt < MIN_PIXELS: the frame is ignored. last_cand, match_cnt, mode_out and mode_locked are unchanged.
  - Otherwise cand = classify(acc), evaluated in priority order:
    - (acc & 0x7F) == 0x7F -> 1
    - (acc & 0x3D) == 0x3D -> 2
    - (acc & 0x1F) == 0x1F -> 3
    - (acc & 0x0F) == 0x0F -> 4
    - (acc & 0x07) == 0x07 -> 5
    - else -> 0
  - Hysteresis:
    - If cand == last_cand: match_cnt <= min(match_cnt + 1, 15).
    - Else: last_cand <= cand; match_cnt <= 1; mode_locked <= 0.
    - When the new match_cnt >= LOCK_FRAMES: mode_out <= cand; mode_locked <= 1.
    - mode_out holds its previous value while unlocked.
  - acc and pix_cnt re-initialise: acc = 0xFF, pix_cnt = 0.
  - If vde_r=1 in the edge cycle, that pixel seeds the new frame: acc = R & G & B, pix_cnt = 1.
- Latency: frame_done, mode_out and mode_locked change on the 2nd rising PixelClk edge after the edge that first samples vid_pVSync=1.
- Level vs. sync: VSync held high for many cycles gives a single frame end. VSync stuck high gives no further frame ends.
- An all-white frame classifies as 1 (0xFF satisfies 0x7F). This is accepted behaviour.
- Mid-frame aRst discards the partial frame. The first frame end after reset is evaluated on pixels seen since reset only.
- Accumulation is a pure AND, so there is no width growth. pix_cnt saturates and never wraps.

Optional Feature:
- Macro: POSTERISE_DETECT_STATS_EN.
- When defined, two extra outputs are added:
  - acc_mask (out, 8): acc value latched at each frame end;
  - pix_count (out, PIX_CNT_W): pix_cnt value latched at each frame end.
  - Both update on the same edge as frame_done, including for ignored frames. Both reset to 0.
- When undefined, these ports and their registers do not exist, and the rest of the behaviour is identical.

Test Plan:
- Reset: assert aRst mid-stream -> all outputs 0 immediately, without waiting for a clock edge. After release, no frame_done until the next VSync rising edge.
- Lv3 frames: 3 frames of 2048 pixels, random bytes OR 0x1F, LOCK_FRAMES=3 -> frame_done pulses each frame; mode_locked=0 after frames 1 and 2; mode_out=3 and mode_locked=1 after frame 3.
- Lv2 mask: bytes random OR 0x3D with bit 1 random and bit 6 forced 0 on some pixels -> cand=2 (not 3, not 1). After 3 frames, mode_out=2.
- Change: locked at 3, then a frame of plain random data -> mode_locked=0, mode_out stays 3. After 3 such frames, mode_out=0 and mode_locked=1.
- Short frame: 500 active pixels of 0x07-masked data -> frame_done pulses; match_cnt, mode_out and mode_locked unchanged. With the macro defined, pix_count=500.
- Edge-cycle pixel: VDE=1 with data 0x00 in the VSync edge cycle -> the closing frame still classifies as lv4 (all its bytes OR 0x0F). The next frame's acc starts at 0x00, so it classifies 0.
